// File: rtl/fetch_stage_pkg.sv
// Shared widths, constants and the fetch-buffer entry type for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned ENTRY_W = XLEN + INST_W;

    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// ICache, EX redirect and IF/ID handshake signals seen by the fetch stage.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [XLEN-1:0]   Addr;
    logic [INST_W-1:0] Inst;
    logic              IStall;
    logic              Redirect;
    logic [XLEN-1:0]   RedirectPC;
    logic              DecodeReady;
    logic              IFValid;
    logic [INST_W-1:0] IFInst;
    logic [XLEN-1:0]   IFPC;

    modport master (
        output Addr, IFValid, IFInst, IFPC,
        input  Inst, IStall, Redirect, RedirectPC, DecodeReady
    );

    modport slave (
        input  Addr, IFValid, IFInst, IFPC,
        output Inst, IStall, Redirect, RedirectPC, DecodeReady
    );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Synchronous FIFO with single-cycle flush; push and pop in one cycle are both honoured.
module fetch_stage_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign rdata  = mem[rd_ptr];
    assign do_pop = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives ICache.Addr, pairs responses with their PC
// and buffers them for decode; EX redirects flush all wrong-path work.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     BUF_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fetch_stage_if.master  bus
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight_valid;

    logic [CW-1:0]   buf_count;
    logic            buf_full;
    logic            buf_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    logic [CW:0]     occupancy_c;
    logic            issue_c;
    logic            push_c;
    logic            pop_c;

    // Issue only if the buffer can absorb everything already in flight plus this request.
    always_comb begin
        occupancy_c = (CW+1)'(buf_count) + (CW+1)'(inflight_valid);
        issue_c     = !bus.Redirect && (occupancy_c < (CW+1)'(BUF_DEPTH));
        push_c      = inflight_valid && !bus.IStall && !bus.Redirect && !buf_full;
        pop_c       = !buf_empty && bus.DecodeReady;
        push_entry  = '{pc: inflight_pc, inst: bus.Inst};
    end

    // ICache samples Addr during refill, so it must stay on the in-flight address while stalled.
    assign bus.Addr = bus.IStall ? inflight_pc : fetch_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc       <= RESET_PC;
            inflight_pc    <= RESET_PC;
            inflight_valid <= 1'b0;
        end else if (bus.Redirect) begin
            fetch_pc       <= bus.RedirectPC & ~XLEN'(3);
            inflight_valid <= 1'b0;
            if (!bus.IStall) begin
                inflight_pc <= fetch_pc;
            end
        end else if (!bus.IStall) begin
            inflight_pc    <= fetch_pc;
            inflight_valid <= issue_c;
            if (issue_c) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
        end
    end

    fetch_stage_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .flush (bus.Redirect),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    assign bus.IFValid = !buf_empty;
    assign bus.IFInst  = buf_empty ? NOP_INST : head_entry.inst;
    assign bus.IFPC    = buf_empty ? '0 : head_entry.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural ICache with programmable misses and a
// program-order scoreboard of expected IFPC/IFInst pairs consumed by decode.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int n_consumed = 0;
    logic [31:0] sb [$];

    // ICache model: one-cycle hit, optional miss of arm_len stall cycles on arm_addr.
    logic [31:0] inst_q;
    logic [31:0] arm_addr = '0;
    int unsigned arm_len   = 0;
    int unsigned arm_id    = 0;
    int unsigned served_id = 0;
    int unsigned stall_cnt = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A0_0000;
    endfunction

    always @(posedge clk) begin
        inst_q <= inst_of(bus.Addr);
        if (!rst) begin
            stall_cnt <= 0;
        end else if (stall_cnt != 0) begin
            stall_cnt <= stall_cnt - 1;
        end else if (arm_id != served_id && bus.Addr == arm_addr) begin
            stall_cnt <= arm_len;
            served_id <= arm_id;
        end
    end

    assign bus.IStall = (stall_cnt != 0);
    assign bus.Inst   = inst_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [31:0] a, input int unsigned len);
        arm_addr = a;
        arm_len  = len;
        arm_id   = arm_id + 1;
    endtask

    task automatic expect_from(input logic [31:0] pc);
        sb.delete();
        for (int i = 0; i < 64; i++) sb.push_back(pc + 32'(4 * i));
    endtask

    // Idle outputs must be NOP/0; every accepted head must match program order.
    task automatic monitor();
        logic [31:0] exp_pc;
        if (bus.IFValid !== 1'b1) begin
            chk("idle_ifinst", bus.IFInst, NOP_INST);
            chk("idle_ifpc", bus.IFPC, 32'h0);
        end else if (rst && bus.DecodeReady && !bus.Redirect) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL sb_underrun: observed pc %h expected no entry", bus.IFPC);
            end
            if (sb.size() != 0) begin
                exp_pc = sb.pop_front();
                chk("ifpc_order", bus.IFPC, exp_pc);
                chk("ifinst_data", bus.IFInst, inst_of(exp_pc));
                n_consumed++;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic red, input logic [31:0] rpc);
        @(negedge clk);
        rst             = r;
        bus.DecodeReady = rdy;
        bus.Redirect    = red;
        bus.RedirectPC  = rpc;
        monitor();
    endtask

    task automatic wait_stall(input logic rdy, input int limit);
        int k = 0;
        while (bus.IStall !== 1'b1 && k < limit) begin
            cyc(1'b1, rdy, 1'b0, 32'h0);
            k++;
        end
        chk("stall_seen", 32'(bus.IStall), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        logic        saw_stall;
        int          c0;

        rst             = 1'b0;
        bus.DecodeReady = 1'b1;
        bus.Redirect    = 1'b0;
        bus.RedirectPC  = '0;
        arm(32'h10, 1);
        expect_from(32'h0);

        // Reset state
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst_ifvalid", 32'(bus.IFValid), 32'h0);
        chk("rst_addr", bus.Addr, 32'h0);

        // Release and all-hit streaming
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rel_addr0", bus.Addr, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rel_addr4", bus.Addr, 32'h4);
        chk("rel_ifvalid_t1", 32'(bus.IFValid), 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rel_addr8", bus.Addr, 32'h8);
        chk("rel_ifvalid_t2", 32'(bus.IFValid), 32'h1);

        // Single-cycle miss at 0x10: address held during stall, no duplicate PC
        saw_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            if (bus.IStall === 1'b1) begin
                saw_stall = 1'b1;
                chk("miss_addr_hold", bus.Addr, 32'h10);
            end
        end
        chk("miss_seen", 32'(saw_stall), 32'h1);

        // Decode back-pressure: buffer fills, fetch stops, then drains in order
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("bp_ifvalid", 32'(bus.IFValid), 32'h1);
        chk("bp_head", bus.IFPC, sb[0]);
        chk("bp_fetch_pc", bus.Addr, sb[0] + 32'h10);
        c0 = n_consumed;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("bp_drain", 32'(n_consumed - c0 >= 6), 32'h1);

        // Redirect with buffered entries; target low bits forced to zero
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("redir_pre_valid", 32'(bus.IFValid), 32'h1);
        cyc(1'b1, 1'b1, 1'b1, 32'h103);
        expect_from(32'h100);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_ifvalid", 32'(bus.IFValid), 32'h0);
        chk("redir_addr", bus.Addr, 32'h100);
        c0 = n_consumed;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_progress", 32'(n_consumed > c0), 32'h1);

        // Redirect during a refill: address holds, refill result dropped
        arm(32'h120, 3);
        wait_stall(1'b1, 40);
        held = bus.Addr;
        chk("refill_addr", held, 32'h120);
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        expect_from(32'h200);
        chk("redir_stall_istall", 32'(bus.IStall), 32'h1);
        chk("redir_stall_addr0", bus.Addr, held);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_stall_addr1", bus.Addr, held);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_stall_release", 32'(bus.IStall), 32'h0);
        chk("redir_stall_target", bus.Addr, 32'h200);
        c0 = n_consumed;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_stall_progress", 32'(n_consumed - c0 >= 4), 32'h1);

        // Reset in the middle of a refill with a non-empty buffer
        arm(32'h308, 4);
        cyc(1'b1, 1'b0, 1'b1, 32'h300);
        expect_from(32'h300);
        wait_stall(1'b0, 40);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_mid_nonempty", 32'(bus.IFValid), 32'h1);
        chk("rst_mid_istall", 32'(bus.IStall), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        expect_from(32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rst_mid_ifvalid", 32'(bus.IFValid), 32'h0);
        chk("rst_mid_addr", bus.Addr, 32'h0);
        chk("rst_mid_ifpc", bus.IFPC, 32'h0);
        c0 = n_consumed;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rst_mid_progress", 32'(n_consumed - c0 >= 4), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
